// File: rtl/siaa_alu_pkg.sv
// -----------------------------------------------------------------------------
// siaa_alu_pkg
// Shared types and constants for the SIAA accumulator-processor ALU.
//   DATA_W    : datapath width (fixed at 8 bits)
//   r_op_e    : R-type opcodes (4-bit rOp field)
//   i_op_e    : I-type opcodes (3-bit iOp field; codes 6 and 7 are reserved)
//   zext_imm  : zero-extends the 5-bit immediate to the datapath width
// -----------------------------------------------------------------------------
package siaa_alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        R_ADD  = 4'h0,
        R_SUB  = 4'h1,
        R_AND  = 4'h2,
        R_OR   = 4'h3,
        R_XOR  = 4'h4,
        R_RXOR = 4'h5,
        R_SLR  = 4'h6,
        R_SRR  = 4'h7,
        R_LW   = 4'h8,
        R_SW   = 4'h9,
        R_EQ   = 4'hA,
        R_SLT  = 4'hB,
        R_BR   = 4'hC,
        R_J    = 4'hD,
        R_SET  = 4'hE,
        R_LA   = 4'hF
    } r_op_e;

    typedef enum logic [2:0] {
        I_ADDI = 3'd0,
        I_SUBI = 3'd1,
        I_ANDI = 3'd2,
        I_SLL  = 3'd3,
        I_SRL  = 3'd4,
        I_SETI = 3'd5
    } i_op_e;

    function automatic logic [DATA_W-1:0] zext_imm(input logic [4:0] imm);
        return {{(DATA_W-5){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/siaa_alu_if.sv
// -----------------------------------------------------------------------------
// siaa_alu_if
// Operand/result bundle between the register file / ACC, the ALU and the
// writeback / PC logic.
//   acc, opReg     : signed 8-bit operands
//   imm            : 5-bit immediate (zero-extended inside the ALU)
//   typeCode       : 0 = R-type (rOp valid), 1 = I-type (iOp valid)
//   rOp, iOp       : opcodes
//   scIn           : carry/borrow-in for add/sub
//   rslt           : 8-bit result
//   scOut          : carry / borrow / last bit shifted out
//   zero, branch   : result-is-zero and take-branch flags
//   scQ            : registered carry flag
// Modports: master drives operands (datapath / testbench), slave is the ALU.
// -----------------------------------------------------------------------------
interface siaa_alu_if;
    import siaa_alu_pkg::*;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] opReg;
    logic [4:0]        imm;
    logic              typeCode;
    logic [3:0]        rOp;
    logic [2:0]        iOp;
    logic              scIn;
    logic [DATA_W-1:0] rslt;
    logic              scOut;
    logic              zero;
    logic              branch;
    logic              scQ;

    modport master (
        output acc, opReg, imm, typeCode, rOp, iOp, scIn,
        input  rslt, scOut, zero, branch, scQ
    );

    modport slave (
        input  acc, opReg, imm, typeCode, rOp, iOp, scIn,
        output rslt, scOut, zero, branch, scQ
    );

endinterface

// File: rtl/siaa_alu_shifter.sv
// -----------------------------------------------------------------------------
// siaa_alu_shifter
// 8-bit logical shifter shared by SLR/SRR/SLL/SRL.
//   data_in    : value to shift
//   amount     : shift distance 0..7
//   shift_left : 1 = shift left, 0 = shift right (zero fill both ways)
//   data_out   : shifted value
//   bit_out    : last bit shifted out (0 when amount is 0)
// -----------------------------------------------------------------------------
module siaa_alu_shifter
    import siaa_alu_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        amount,
    input  logic              shift_left,
    output logic [DATA_W-1:0] data_out,
    output logic              bit_out
);

    // Shifting one extra guard bit along with the data leaves the last bit
    // that fell off in the guard position; for amount 0 the guard stays 0.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        data_out = data_in;
        bit_out  = 1'b0;
        if (shift_left) begin
            {bit_out, data_out} = {1'b0, data_in} << amount;
        end else begin
            {data_out, bit_out} = {data_in, 1'b0} >> amount;
        end
    end

endmodule

// File: rtl/siaa_alu.sv
// -----------------------------------------------------------------------------
// siaa_alu
// 8-bit ALU of the SIAA accumulator processor. Decodes R-type and I-type
// operations into result, carry/shift-out, zero and branch flags. The datapath
// is combinational; a carry flop (scQ) keeps the last scOut for multi-byte
// arithmetic.
//   clk   : clock
//   rst_n : asynchronous active-low reset (clears scQ and, when registered,
//           the outputs)
//   bus   : siaa_alu_if.slave - operands in, rslt/scOut/zero/branch/scQ out
// Build option:
//   ALU_OUT_REG_EN : when defined, rslt/scOut/zero/branch are registered
//                    (1-cycle latency, 0 in reset); scQ is then the same flop
//                    as the registered scOut. Undefined: outputs are
//                    combinational and only scQ is a flop.
// -----------------------------------------------------------------------------
module siaa_alu
    import siaa_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    siaa_alu_if.slave   bus
);

    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;
    logic [2:0]        shift_amt;
    logic              shift_left;
    logic [DATA_W-1:0] shift_res;
    logic              shift_bit;

    logic [DATA_W-1:0] rslt_d;
    logic              sc_d;
    logic              branch_d;
    logic              zero_d;
    logic              sc_q;

    // Second operand: register for R-type, zero-extended immediate for I-type,
    // so one adder and one subtractor serve ADD/ADDI and SUB/SUBI.
    assign imm8 = zext_imm(bus.imm);
    assign b_op = bus.typeCode ? imm8 : bus.opReg;

    // One extra bit on top holds the carry out (add) or the borrow (sub):
    // a negative 9-bit difference sets bit 8.
    assign add_sum  = {1'b0, bus.acc} + {1'b0, b_op} + {{DATA_W{1'b0}}, bus.scIn};
    assign sub_diff = {1'b0, bus.acc} - {1'b0, b_op} - {{DATA_W{1'b0}}, bus.scIn};

    assign shift_amt  = bus.typeCode ? bus.imm[2:0] : bus.opReg[2:0];
    assign shift_left = bus.typeCode ? (bus.iOp == I_SLL) : (bus.rOp == R_SLR);

    siaa_alu_shifter u_shifter (
        .data_in    (bus.acc),
        .amount     (shift_amt),
        .shift_left (shift_left),
        .data_out   (shift_res),
        .bit_out    (shift_bit)
    );

    always_comb begin
        rslt_d   = '0;
        sc_d     = 1'b0;
        branch_d = 1'b0;
        if (!bus.typeCode) begin
            case (r_op_e'(bus.rOp))
                R_ADD:  {sc_d, rslt_d} = add_sum;
                R_SUB:  {sc_d, rslt_d} = sub_diff;
                R_AND:  rslt_d = bus.acc & bus.opReg;
                R_OR:   rslt_d = bus.acc | bus.opReg;
                R_XOR:  rslt_d = bus.acc ^ bus.opReg;
                R_RXOR: rslt_d = {{(DATA_W-1){1'b0}}, ^bus.opReg};
                R_SLR, R_SRR: begin
                    rslt_d = shift_res;
                    sc_d   = shift_bit;
                end
                R_LW, R_SW, R_LA: rslt_d = bus.opReg;
                R_EQ:   rslt_d = {{(DATA_W-1){1'b0}}, bus.acc == bus.opReg};
                R_SLT:  rslt_d = {{(DATA_W-1){1'b0}},
                                  $signed(bus.acc) < $signed(bus.opReg)};
                R_BR: begin
                    rslt_d   = bus.opReg;
                    branch_d = (bus.acc != '0);
                end
                R_J: begin
                    rslt_d   = bus.opReg;
                    branch_d = 1'b1;
                end
                R_SET:  rslt_d = bus.acc;
                default: rslt_d = '0;
            endcase
        end else begin
            // I-type never branches; codes 6 and 7 keep the all-zero defaults.
            case (bus.iOp)
                I_ADDI: {sc_d, rslt_d} = add_sum;
                I_SUBI: {sc_d, rslt_d} = sub_diff;
                I_ANDI: rslt_d = bus.acc & imm8;
                I_SLL, I_SRL: begin
                    rslt_d = shift_res;
                    sc_d   = shift_bit;
                end
                I_SETI: rslt_d = imm8;
                default: rslt_d = '0;
            endcase
        end
    end

    assign zero_d = (rslt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (!rst_n) begin
            sc_q <= 1'b0;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign bus.scQ = sc_q;

`ifdef ALU_OUT_REG_EN
    logic [DATA_W-1:0] rslt_q;
    logic              zero_q;
    logic              branch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt_q   <= '0;
            zero_q   <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            rslt_q   <= rslt_d;
            zero_q   <= zero_d;
            branch_q <= branch_d;
        end
    end

    assign bus.rslt   = rslt_q;
    assign bus.scOut  = sc_q;
    assign bus.zero   = zero_q;
    assign bus.branch = branch_q;
`else
    assign bus.rslt   = rslt_d;
    assign bus.scOut  = sc_d;
    assign bus.zero   = zero_d;
    assign bus.branch = branch_d;
`endif

endmodule

// File: tb/tb_siaa_alu.sv
// -----------------------------------------------------------------------------
// tb_siaa_alu
// Directed self-checking bench for siaa_alu. Works with either build; with
// ALU_OUT_REG_EN defined, results are sampled one clock edge after the inputs.
// -----------------------------------------------------------------------------
module tb_siaa_alu;
    import siaa_alu_pkg::*;

    typedef struct packed {
        logic       t;
        logic [3:0] rop;
        logic [2:0] iop;
        logic [7:0] acc;
        logic [7:0] opr;
        logic [4:0] imm;
        logic       sci;
        logic [7:0] rs;
        logic       sc;
        logic       z;
        logic       br;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;

    siaa_alu_if bus ();

    siaa_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk_r(input logic [3:0] rop, input logic [7:0] acc,
                                  input logic [7:0] opr, input logic sci,
                                  input logic [7:0] rs, input logic sc,
                                  input logic z, input logic br);
        return '{t: 1'b0, rop: rop, iop: 3'd7, acc: acc, opr: opr, imm: 5'd31,
                 sci: sci, rs: rs, sc: sc, z: z, br: br};
    endfunction

    // I-type vectors carry a J opcode in rOp to show it is ignored.
    function automatic vec_t mk_i(input logic [2:0] iop, input logic [7:0] acc,
                                  input logic [4:0] imm, input logic sci,
                                  input logic [7:0] rs, input logic sc,
                                  input logic z);
        return '{t: 1'b1, rop: R_J, iop: iop, acc: acc, opr: 8'hFF, imm: imm,
                 sci: sci, rs: rs, sc: sc, z: z, br: 1'b0};
    endfunction

    task automatic drive(input vec_t v);
        bus.typeCode = v.t;
        bus.rOp      = v.rop;
        bus.iOp      = v.iop;
        bus.acc      = v.acc;
        bus.opReg    = v.opr;
        bus.imm      = v.imm;
        bus.scIn     = v.sci;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
`ifdef ALU_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(mk_r(R_ADD, 8'd44, 8'd45, 1'b0, 8'd89, 1'b0, 1'b0, 1'b0));
        #3;
        tests_run++;
        if (bus.scQ !== 1'b0) begin
            fails++;
            $display("FAIL reset_scq: got %b want 0", bus.scQ);
        end
        tests_run++;
`ifdef ALU_OUT_REG_EN
        if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rslt=%h sc=%b z=%b br=%b want all 0",
                     bus.rslt, bus.scOut, bus.zero, bus.branch);
        end
`else
        if (bus.rslt !== 8'd89) begin
            fails++;
            $display("FAIL reset_comb_rslt: got %0d want 89", bus.rslt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_r_arith;
        vec_t v [6];
        v = '{mk_r(R_ADD, 8'd44,  8'd45,  1'b0, 8'd89,  1'b0, 1'b0, 1'b0),
              mk_r(R_ADD, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0),
              mk_r(R_ADD, 8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b1, 1'b0),
              mk_r(R_SUB, 8'd45,  8'd44,  1'b0, 8'd1,   1'b0, 1'b0, 1'b0),
              mk_r(R_SUB, 8'd0,   8'd1,   1'b0, 8'hFF,  1'b1, 1'b0, 1'b0),
              mk_r(R_SUB, 8'd10,  8'd3,   1'b1, 8'd6,   1'b0, 1'b0, 1'b0)};
        foreach (v[i]) begin
            apply(v[i]);
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !==
                {v[i].rs, v[i].sc, v[i].z, v[i].br}) begin
                fails++;
                $display("FAIL r_arith[%0d]: got rslt=%h sc=%b z=%b br=%b want rslt=%h sc=%b z=%b br=%b",
                         i, bus.rslt, bus.scOut, bus.zero, bus.branch,
                         v[i].rs, v[i].sc, v[i].z, v[i].br);
            end
        end
    endtask

    task automatic test_r_logic;
        vec_t v [5];
        v = '{mk_r(R_AND,  8'h2C, 8'h2D, 1'b1, 8'h2C, 1'b0, 1'b0, 1'b0),
              mk_r(R_OR,   8'h2C, 8'h2D, 1'b1, 8'h2D, 1'b0, 1'b0, 1'b0),
              mk_r(R_XOR,  8'h2C, 8'h2D, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0),
              mk_r(R_RXOR, 8'h2C, 8'h2D, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0),
              mk_r(R_RXOR, 8'h2C, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0)};
        foreach (v[i]) begin
            apply(v[i]);
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !==
                {v[i].rs, v[i].sc, v[i].z, v[i].br}) begin
                fails++;
                $display("FAIL r_logic[%0d]: got rslt=%h sc=%b z=%b br=%b want rslt=%h sc=%b z=%b br=%b",
                         i, bus.rslt, bus.scOut, bus.zero, bus.branch,
                         v[i].rs, v[i].sc, v[i].z, v[i].br);
            end
        end
    endtask

    task automatic test_r_shift_cmp;
        vec_t v [11];
        v = '{mk_r(R_SLR, 8'h2C, 8'd2,   1'b0, 8'hB0, 1'b0, 1'b0, 1'b0),
              mk_r(R_SRR, 8'h2C, 8'd2,   1'b0, 8'h0B, 1'b0, 1'b0, 1'b0),
              mk_r(R_SLR, 8'h2C, 8'd3,   1'b0, 8'h60, 1'b1, 1'b0, 1'b0),
              mk_r(R_SRR, 8'h2C, 8'd3,   1'b0, 8'h05, 1'b1, 1'b0, 1'b0),
              mk_r(R_SLR, 8'h2C, 8'd8,   1'b0, 8'h2C, 1'b0, 1'b0, 1'b0),
              mk_r(R_SLT, 8'd44, 8'd45,  1'b0, 8'd1,  1'b0, 1'b0, 1'b0),
              mk_r(R_SLT, 8'd44, 8'd32,  1'b0, 8'd0,  1'b0, 1'b1, 1'b0),
              mk_r(R_SLT, 8'd44, 8'd44,  1'b0, 8'd0,  1'b0, 1'b1, 1'b0),
              mk_r(R_SLT, 8'hFF, 8'd1,   1'b0, 8'd1,  1'b0, 1'b0, 1'b0),
              mk_r(R_EQ,  8'd44, 8'd44,  1'b0, 8'd1,  1'b0, 1'b0, 1'b0),
              mk_r(R_EQ,  8'd0,  8'd127, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0)};
        foreach (v[i]) begin
            apply(v[i]);
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !==
                {v[i].rs, v[i].sc, v[i].z, v[i].br}) begin
                fails++;
                $display("FAIL r_shift_cmp[%0d]: got rslt=%h sc=%b z=%b br=%b want rslt=%h sc=%b z=%b br=%b",
                         i, bus.rslt, bus.scOut, bus.zero, bus.branch,
                         v[i].rs, v[i].sc, v[i].z, v[i].br);
            end
        end
    endtask

    task automatic test_r_control;
        vec_t v [7];
        v = '{mk_r(R_BR,  8'd1,  8'h20,  1'b0, 8'h20,  1'b0, 1'b0, 1'b1),
              mk_r(R_BR,  8'd0,  8'h20,  1'b0, 8'h20,  1'b0, 1'b0, 1'b0),
              mk_r(R_J,   8'd0,  8'h10,  1'b0, 8'h10,  1'b0, 1'b0, 1'b1),
              mk_r(R_LW,  8'd44, 8'd127, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0),
              mk_r(R_SW,  8'd44, 8'd127, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0),
              mk_r(R_SET, 8'd44, 8'd0,   1'b0, 8'd44,  1'b0, 1'b0, 1'b0),
              mk_r(R_LA,  8'd0,  8'd45,  1'b0, 8'd45,  1'b0, 1'b0, 1'b0)};
        foreach (v[i]) begin
            apply(v[i]);
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !==
                {v[i].rs, v[i].sc, v[i].z, v[i].br}) begin
                fails++;
                $display("FAIL r_control[%0d]: got rslt=%h sc=%b z=%b br=%b want rslt=%h sc=%b z=%b br=%b",
                         i, bus.rslt, bus.scOut, bus.zero, bus.branch,
                         v[i].rs, v[i].sc, v[i].z, v[i].br);
            end
        end
    endtask

    task automatic test_i_type;
        vec_t v [10];
        v = '{mk_i(I_ADDI, 8'd44,  5'd31, 1'b0, 8'd75,  1'b0, 1'b0),
              mk_i(I_ADDI, 8'd250, 5'd10, 1'b1, 8'd5,   1'b1, 1'b0),
              mk_i(I_SUBI, 8'd32,  5'd31, 1'b0, 8'd1,   1'b0, 1'b0),
              mk_i(I_SUBI, 8'd0,   5'd1,  1'b0, 8'hFF,  1'b1, 1'b0),
              mk_i(I_ANDI, 8'h2C,  5'h0D, 1'b0, 8'h0C,  1'b0, 1'b0),
              mk_i(I_SLL,  8'h2C,  5'd2,  1'b0, 8'hB0,  1'b0, 1'b0),
              mk_i(I_SRL,  8'h2C,  5'd2,  1'b0, 8'h0B,  1'b0, 1'b0),
              mk_i(I_SRL,  8'h2C,  5'd3,  1'b0, 8'h05,  1'b1, 1'b0),
              mk_i(I_SLL,  8'h2C,  5'd8,  1'b0, 8'h2C,  1'b0, 1'b0),
              mk_i(I_SETI, 8'd0,   5'd25, 1'b0, 8'd25,  1'b0, 1'b0)};
        foreach (v[i]) begin
            apply(v[i]);
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.zero, bus.branch} !==
                {v[i].rs, v[i].sc, v[i].z, v[i].br}) begin
                fails++;
                $display("FAIL i_type[%0d]: got rslt=%h sc=%b z=%b br=%b want rslt=%h sc=%b z=%b br=%b",
                         i, bus.rslt, bus.scOut, bus.zero, bus.branch,
                         v[i].rs, v[i].sc, v[i].z, v[i].br);
            end
        end
    endtask

    task automatic test_reserved;
        for (int op = 6; op < 8; op++) begin
            apply(mk_i(3'(op), 8'h2C, 5'd5, 1'b1, 8'd0, 1'b0, 1'b1));
            tests_run++;
            if ({bus.rslt, bus.scOut, bus.branch} !== 10'd0) begin
                fails++;
                $display("FAIL i_reserved[%0d]: got rslt=%h sc=%b br=%b want rslt=00 sc=0 br=0",
                         op, bus.rslt, bus.scOut, bus.branch);
            end
        end
    endtask

    task automatic test_carry_flag;
        apply(mk_r(R_ADD, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.scQ !== 1'b1) begin
            fails++;
            $display("FAIL scq_capture: got %b want 1", bus.scQ);
        end
        // Assert reset between edges and look before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.scQ !== 1'b0) begin
            fails++;
            $display("FAIL scq_async_reset: got %b want 0", bus.scQ);
        end
`ifdef ALU_OUT_REG_EN
        tests_run++;
        if ({bus.rslt, bus.scOut} !== 9'd0) begin
            fails++;
            $display("FAIL reg_async_reset: got rslt=%h sc=%b want 0", bus.rslt, bus.scOut);
        end
`endif
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.scQ !== 1'b0) begin
            fails++;
            $display("FAIL scq_hold_in_reset: got %b want 0", bus.scQ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk_r(R_ADD, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        apply(mk_r(R_ADD, 8'd44, 8'd45, 1'b0, 8'd89, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.scQ !== 1'b0) begin
            fails++;
            $display("FAIL scq_clear: got %b want 0", bus.scQ);
        end
    endtask

`ifdef ALU_OUT_REG_EN
    task automatic test_latency;
        apply(mk_r(R_SET, 8'd44, 8'd0, 1'b0, 8'd44, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk_r(R_LA, 8'd0, 8'd45, 1'b0, 8'd45, 1'b0, 1'b0, 1'b0));
        #1;
        tests_run++;
        if (bus.rslt !== 8'd44) begin
            fails++;
            $display("FAIL latency_hold: got %0d want 44", bus.rslt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.rslt !== 8'd45) begin
            fails++;
            $display("FAIL latency_update: got %0d want 45", bus.rslt);
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_r_arith();
        test_r_logic();
        test_r_shift_cmp();
        test_r_control();
        test_i_type();
        test_reserved();
        test_carry_flag();
`ifdef ALU_OUT_REG_EN
        test_latency();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
